ami_port_merge: RTL and testbench

- Sits directly downstream of the block buffer in the dnnweaver AMI path.
- Merges the block buffer's two AMI request ports (port 0 read/fill, port 1 write/evict) onto one physical AMI memory channel.
- Routes in-order read responses back to the issuing port via a tag FIFO.
- Lets the accelerator run on a shell that exposes a single AMI port.

---
 rtl/ami_port_merge.sv | 110 +++++++++++
 tb/tb_ami_port_merge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ami_port_merge.sv
// ami_port_merge: merges the block buffer's two AMI request ports onto one memory channel
// and routes in-order read responses back to the issuing port through a tag FIFO.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req_in/req_in_grant upstream requests and per-port accept strobes
//   resp_out/resp_out_grant routed read responses and upstream consume strobes
//   mem_req/mem_req_grant   merged request (output holding register) and memory accept
//   mem_resp/mem_resp_grant in-order read responses from memory and consume strobe
//   outstanding         tag FIFO occupancy
//   err_orphan_resp     sticky: a response arrived with no read outstanding
package ami_port_merge_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 6;
    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
    } ami_req_t;
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
    } ami_resp_t;
endpackage

module ami_port_merge
    import ami_port_merge_pkg::*;
#(
    parameter int NUM_IN          = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int PORT_W          = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  ami_req_t            req_in [NUM_IN],
    output logic [NUM_IN-1:0]   req_in_grant,
    output ami_resp_t           resp_out [NUM_IN],
    input  logic [NUM_IN-1:0]   resp_out_grant,
    output ami_req_t            mem_req,
    input  logic                mem_req_grant,
    input  ami_resp_t           mem_resp,
    output logic                mem_resp_grant,
    output logic [PORT_W+3:0]   outstanding,
    output logic                err_orphan_resp
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PORT_W + 4;

    logic [PORT_W-1:0] last_q, sel, head;
    logic [PORT_W-1:0] tag_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [NUM_IN-1:0] elig;
    logic              full, empty, ohr_free, any, push, pop;

    // Full is judged without the same-cycle pop so the response grant path never feeds req_in_grant.
    assign full     = outstanding == CNT_W'(MAX_OUTSTANDING);
    assign empty    = outstanding == '0;
    assign ohr_free = !mem_req.valid || mem_req_grant;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++)
            elig[i] = req_in[i].valid && (req_in[i].is_write || !full);
    end

    // Two-port round robin: on a tie the port after the last-granted one wins.
    assign sel          = (elig[0] && elig[1]) ? ~last_q : elig[1];
    assign any          = ohr_free && |elig;
    assign req_in_grant = any ? NUM_IN'(1) << sel : '0;
    assign push         = any && !req_in[sel].is_write;
    assign head         = tag_q[rd_ptr];
    assign pop          = !empty && mem_resp.valid && mem_resp_grant;

    // With nothing outstanding the response is swallowed as an orphan.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            resp_out[i]       = mem_resp;
            resp_out[i].valid = mem_resp.valid && !empty && head == PORT_W'(i);
        end
        mem_resp_grant = empty ? mem_resp.valid : resp_out_grant[head];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req         <= '0;
            last_q          <= PORT_W'(NUM_IN - 1);
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outstanding     <= '0;
            err_orphan_resp <= 1'b0;
        end else begin
            if (any) begin
                mem_req <= req_in[sel];
                last_q  <= sel;
            end else if (mem_req_grant) begin
                mem_req <= '0;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
            if (empty && mem_resp.valid) err_orphan_resp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_q[wr_ptr] <= sel;
    end
endmodule

// File: tb/tb_ami_port_merge.sv
// tb_ami_port_merge: directed self-checking bench for ami_port_merge
module tb_ami_port_merge;
    import ami_port_merge_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    ami_req_t   req_in [2];
    logic [1:0] req_in_grant;
    ami_resp_t  resp_out [2];
    logic [1:0] resp_out_grant;
    ami_req_t   mem_req;
    logic       mem_req_grant;
    ami_resp_t  mem_resp;
    logic       mem_resp_grant;
    logic [4:0] outstanding;
    logic       err_orphan_resp;
    int         n_checks = 0;
    int         n_errors = 0;

    ami_port_merge dut (
        .clk(clk), .reset(reset),
        .req_in(req_in), .req_in_grant(req_in_grant),
        .resp_out(resp_out), .resp_out_grant(resp_out_grant),
        .mem_req(mem_req), .mem_req_grant(mem_req_grant),
        .mem_resp(mem_resp), .mem_resp_grant(mem_resp_grant),
        .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic [63:0] a);
        req_in[p].valid    = v;
        req_in[p].is_write = w;
        req_in[p].addr     = a;
        req_in[p].data     = a + 64'h5;
        req_in[p].size     = 6'd8;
    endtask

    task automatic respond(input logic v, input logic [63:0] d);
        mem_resp.valid = v;
        mem_resp.data  = d;
        mem_resp.size  = 6'd8;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        respond(0, 0);
        resp_out_grant = 2'b00;
        mem_req_grant  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_outstanding", 64'(outstanding), 0);
        check("rst_mem_valid", 64'(mem_req.valid), 0);
        check("rst_mem_addr", mem_req.addr, 0);
        check("rst_err", 64'(err_orphan_resp), 0);
        check("rst_grant", 64'(req_in_grant), 0);
        check("rst_resp_grant", 64'(mem_resp_grant), 0);
        check("rst_resp_valid", 64'({resp_out[1].valid, resp_out[0].valid}), 0);

        // single read from port 0
        drive(0, 1, 0, 64'h1000);
        #1 check("rd_grant", 64'(req_in_grant), 64'b01);
        step();
        drive(0, 0, 0, 0);
        check("rd_mem_valid", 64'(mem_req.valid), 1);
        check("rd_mem_addr", mem_req.addr, 64'h1000);
        check("rd_mem_write", 64'(mem_req.is_write), 0);
        check("rd_outstanding", 64'(outstanding), 1);
        mem_req_grant = 1'b1;
        step();
        mem_req_grant = 1'b0;
        check("rd_ohr_clear", 64'(mem_req.valid), 0);
        respond(1, 64'hAB);
        resp_out_grant = 2'b01;
        #1;
        check("rd_resp0_valid", 64'(resp_out[0].valid), 1);
        check("rd_resp0_data", resp_out[0].data, 64'hAB);
        check("rd_resp1_valid", 64'(resp_out[1].valid), 0);
        check("rd_mem_resp_grant", 64'(mem_resp_grant), 1);
        step();
        respond(0, 0);
        check("rd_outstanding_end", 64'(outstanding), 0);

        // tie: port 0 read vs port 1 write, memory always ready
        do_reset();
        drive(0, 1, 0, 64'h10);
        drive(1, 1, 1, 64'h20);
        mem_req_grant = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 check($sformatf("rr_grant%0d", c), 64'(req_in_grant), (c % 2 == 0) ? 64'b01 : 64'b10);
            step();
            check($sformatf("rr_valid%0d", c), 64'(mem_req.valid), 1);
            check($sformatf("rr_write%0d", c), 64'(mem_req.is_write), (c % 2 == 0) ? 64'd0 : 64'd1);
        end
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        step();
        check("rr_outstanding", 64'(outstanding), 2);
        check("rr_drained", 64'(mem_req.valid), 0);

        // backpressure: read 0x40 held in the register for five cycles
        do_reset();
        drive(0, 1, 0, 64'h40);
        step();
        drive(0, 1, 0, 64'h44);
        drive(1, 1, 1, 64'h80);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_grant%0d", c), 64'(req_in_grant), 0);
            check($sformatf("bp_addr%0d", c), mem_req.addr, 64'h40);
            check($sformatf("bp_valid%0d", c), 64'(mem_req.valid), 1);
            step();
        end
        mem_req_grant = 1'b1;
        #1 check("bp_accept_grant", 64'(req_in_grant), 64'b10);
        step();
        check("bp_next_addr", mem_req.addr, 64'h80);
        check("bp_next_write", 64'(mem_req.is_write), 1);

        // tag FIFO full: eight reads, then a stalled ninth
        do_reset();
        mem_req_grant = 1'b1;
        drive(0, 1, 0, 64'h200);
        for (int c = 0; c < 8; c++) step();
        check("full_outstanding", 64'(outstanding), 8);
        drive(1, 1, 1, 64'h300);
        #1 check("full_write_granted", 64'(req_in_grant), 64'b10);
        step();
        drive(1, 0, 0, 0);
        #1 check("full_read_stalled", 64'(req_in_grant), 0);
        respond(1, 64'h77);
        resp_out_grant = 2'b01;
        #1 check("full_no_push_on_pop", 64'(req_in_grant), 0);
        step();
        respond(0, 0);
        check("full_after_pop", 64'(outstanding), 7);
        #1 check("full_read_resumes", 64'(req_in_grant), 64'b01);
        step();
        check("full_refilled", 64'(outstanding), 8);

        // interleaved routing p0,p1,p1,p0
        do_reset();
        mem_req_grant = 1'b1;
        drive(0, 1, 0, 64'h1); step(); drive(0, 0, 0, 0);
        drive(1, 1, 0, 64'h2); step(); step(); drive(1, 0, 0, 0);
        drive(0, 1, 0, 64'h4); step(); drive(0, 0, 0, 0);
        check("il_outstanding", 64'(outstanding), 4);
        resp_out_grant = 2'b01;
        respond(1, 64'h1);
        #1;
        check("il_r1_p0", resp_out[0].data, 64'h1);
        check("il_r1_v", 64'({resp_out[1].valid, resp_out[0].valid}), 64'b01);
        step();
        respond(1, 64'h2);
        #1;
        check("il_r2_v", 64'({resp_out[1].valid, resp_out[0].valid}), 64'b10);
        check("il_r2_p1", resp_out[1].data, 64'h2);
        check("il_r2_blocked", 64'(mem_resp_grant), 0);
        step();
        check("il_r2_held", 64'(outstanding), 3);
        resp_out_grant = 2'b11;
        #1 check("il_r2_grant", 64'(mem_resp_grant), 1);
        step();
        respond(1, 64'h3);
        #1;
        check("il_r3_v", 64'({resp_out[1].valid, resp_out[0].valid}), 64'b10);
        check("il_r3_p1", resp_out[1].data, 64'h3);
        step();
        respond(1, 64'h4);
        #1;
        check("il_r4_v", 64'({resp_out[1].valid, resp_out[0].valid}), 64'b01);
        check("il_r4_p0", resp_out[0].data, 64'h4);
        step();
        respond(0, 0);
        check("il_outstanding_end", 64'(outstanding), 0);

        // orphan response, then asynchronous reset mid-burst
        resp_out_grant = 2'b00;
        respond(1, 64'hDEAD);
        #1;
        check("orph_grant", 64'(mem_resp_grant), 1);
        check("orph_no_valid", 64'({resp_out[1].valid, resp_out[0].valid}), 0);
        step();
        respond(0, 0);
        check("orph_err", 64'(err_orphan_resp), 1);
        drive(0, 1, 0, 64'h500);
        for (int c = 0; c < 3; c++) step();
        check("ar_outstanding_pre", 64'(outstanding), 3);
        #1 reset = 1'b0;
        #1;
        check("ar_outstanding", 64'(outstanding), 0);
        check("ar_mem_valid", 64'(mem_req.valid), 0);
        check("ar_err", 64'(err_orphan_resp), 0);
        idle();
        step();
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
